// File: rtl/vga_bus_capture_if.sv
// ============================================================================
// vga_bus_capture_if
// ----------------------------------------------------------------------------
// Purpose : Groups the 6502 bus-side signals and the command-FIFO consumer
//           signals of vga_bus_capture into a single bundle.
//
// Signals :
//   CLK_CPU    6502 PHI2, asynchronous to CLK_FAST
//   EN         chip enable, active-low, asynchronous
//   RW         CPU read/write, 0 = write, asynchronous
//   REG[2:0]   register select, asynchronous
//   DATA[7:0]  CPU write data, asynchronous
//   CMD_VALID  FIFO head holds a command
//   CMD_REG    head register index
//   CMD_DATA   head data byte
//   CMD_READY  consumer accepts head this cycle
//   LEVEL      entries currently stored, $clog2(DEPTH)+1 bits
//   OVF        sticky overflow flag
//   CLR_OVF    synchronous clear of OVF
//
// Modports:
//   master  the surrounding system (CPU bus driver + command consumer)
//   slave   the capture block itself
// ============================================================================
interface vga_bus_capture_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    // CPU bus side
    logic          CLK_CPU;
    logic          EN;
    logic          RW;
    logic [2:0]    REG;
    logic [7:0]    DATA;

    // Command consumer side
    logic          CMD_VALID;
    logic [2:0]    CMD_REG;
    logic [7:0]    CMD_DATA;
    logic          CMD_READY;
    logic [LW-1:0] LEVEL;
    logic          OVF;
    logic          CLR_OVF;

    modport master (
        output CLK_CPU, EN, RW, REG, DATA, CMD_READY, CLR_OVF,
        input  CMD_VALID, CMD_REG, CMD_DATA, LEVEL, OVF
    );

    modport slave (
        input  CLK_CPU, EN, RW, REG, DATA, CMD_READY, CLR_OVF,
        output CMD_VALID, CMD_REG, CMD_DATA, LEVEL, OVF
    );
endinterface

// File: rtl/vga_bus_capture.sv
// ============================================================================
// vga_bus_capture
// ----------------------------------------------------------------------------
// Purpose : Captures 6502 register writes into a first-word-fall-through
//           command FIFO running in the CLK_FAST domain.
//
//           PHI2 and the bus are each passed through three flops in lockstep.
//           A PHI2 falling edge is seen as c3=1 & c2=0; at that moment b3
//           holds the last bus sample taken while PHI2 was still high, so it
//           is the settled write cycle. The strobe is registered once more
//           before it reaches the FIFO, so a fall first sampled at edge n is
//           stored at edge n+3.
//
// Ports   :
//   CLK_FAST  sole clock, all state changes on its rising edge
//   RESET     asynchronous, active-low reset
//   bus       vga_bus_capture_if.slave (CPU bus in, command FIFO out)
//
// Parameters:
//   DEPTH     command FIFO entries, power of two in 4..64
// ============================================================================
module vga_bus_capture #(
    parameter int DEPTH = 16
) (
    input logic              CLK_FAST,
    input logic              RESET,
    vga_bus_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic       en;
        logic       rw;
        logic [2:0] reg_sel;
        logic [7:0] data;
    } bus_sample_t;

    // Entry layout: [10:8] register index, [7:0] data byte.
    typedef logic [10:0] entry_t;

    // ------------------------------------------------------------------
    // Synchronisers: PHI2 chain and bus chain advance in lockstep
    // ------------------------------------------------------------------
    logic        c1, c2, c3;
    bus_sample_t b1, b2, b3;
    bus_sample_t bus_now;

    assign bus_now = {bus.EN, bus.RW, bus.REG, bus.DATA};

    // NOTE: state registers use non-blocking assignments so every flop in
    // the chain samples the pre-edge value of its neighbour.
    always_ff @(posedge CLK_FAST or negedge RESET) begin
        if (!RESET) begin
            c1 <= 1'b0;
            c2 <= 1'b0;
            c3 <= 1'b0;
            b1 <= '0;
            b2 <= '0;
            b3 <= '0;
        end else begin
            c1 <= bus.CLK_CPU;
            c2 <= c1;
            c3 <= c2;
            b1 <= bus_now;
            b2 <= b1;
            b3 <= b2;
        end
    end

    // The 1->0 pair is only present for a single cycle, so a long PHI2-low
    // phase can never produce a second push. Chain reset to 0 keeps a fall
    // from being reported until PHI2 has been sampled high after reset.
    logic write_strobe;
    assign write_strobe = c3 & ~c2 & ~b3.en & ~b3.rw;

    logic   push_q;
    entry_t push_entry_q;

    always_ff @(posedge CLK_FAST or negedge RESET) begin
        if (!RESET) begin
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q       <= write_strobe;
            push_entry_q <= {b3.reg_sel, b3.data};
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;

    logic pop;
    logic full;
    logic accept;
    logic overflow;

    assign pop      = (level != '0) && bus.CMD_READY;
    assign full     = (level == LW'(DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still accepted in that cycle.
    assign accept   = push_q && (!full || pop);
    assign overflow = push_q && full && !pop;

    // NOTE: storage has no reset; an entry is only visible once the
    // pointers and level (which are reset) say it was written.
    always_ff @(posedge CLK_FAST) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry_q;
        end
    end

    always_ff @(posedge CLK_FAST or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Overflow wins over a clear in the same cycle.
    always_ff @(posedge CLK_FAST or negedge RESET) begin
        if (!RESET) begin
            ovf <= 1'b0;
        end else if (overflow) begin
            ovf <= 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head read combinationally from storage
    // ------------------------------------------------------------------
    entry_t head;
    assign head = mem[rd_ptr];

    assign bus.CMD_VALID = (level != '0);
    assign bus.CMD_REG   = head[10:8];
    assign bus.CMD_DATA  = head[7:0];
    assign bus.LEVEL     = level;
    assign bus.OVF       = ovf;

endmodule

// File: tb/tb_vga_bus_capture.sv
// ============================================================================
// tb_vga_bus_capture
// ----------------------------------------------------------------------------
// Randomised and directed stimulus for vga_bus_capture, checked every cycle
// against a queue-based model of the capture rules, plus literal
// expectations for the fixed scenarios.
// ============================================================================
module tb_vga_bus_capture;
    localparam int DEPTH = 16;

    logic CLK_FAST = 1'b0;
    logic RESET    = 1'b0;

    vga_bus_capture_if #(.DEPTH(DEPTH)) ifc ();

    vga_bus_capture #(.DEPTH(DEPTH)) dut (
        .CLK_FAST (CLK_FAST),
        .RESET    (RESET),
        .bus      (ifc.slave)
    );

    always #5 CLK_FAST = ~CLK_FAST;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a write is a PHI2 sample of 1 followed by a sample
    // of 0, with the bus (taken at the 1 sample) showing EN=0, RW=0. It
    // lands in the queue three edges after the 0 sample.
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [10:0] e;
    } pend_t;

    pend_t       pend [$];
    logic [10:0] mq [$];
    bit          m_ovf    = 1'b0;
    int          cyc      = 0;
    bit          prev_phi = 1'b0;
    logic [12:0] prev_bus = '0;
    bit          m_pop;
    bit          m_push;
    bit          m_drop;
    logic [10:0] m_pe;
    pend_t       m_new;

    always @(posedge CLK_FAST or negedge RESET) begin
        if (!RESET) begin
            pend.delete();
            mq.delete();
            m_ovf    = 1'b0;
            prev_phi = 1'b0;
            prev_bus = '0;
        end else begin
            cyc++;
            m_pop  = (mq.size() != 0) && ifc.CMD_READY;
            m_push = 1'b0;
            m_pe   = '0;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                m_push = 1'b1;
                m_pe   = pend[0].e;
                void'(pend.pop_front());
            end
            m_drop = m_push && (mq.size() == DEPTH) && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push && !m_drop) mq.push_back(m_pe);
            if (m_drop) m_ovf = 1'b1;
            else if (ifc.CLR_OVF) m_ovf = 1'b0;
            if (prev_phi && !ifc.CLK_CPU && !prev_bus[12] && !prev_bus[11]) begin
                m_new.due = cyc + 3;
                m_new.e   = prev_bus[10:0];
                pend.push_back(m_new);
            end
            prev_phi = ifc.CLK_CPU;
            prev_bus = {ifc.EN, ifc.RW, ifc.REG, ifc.DATA};
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    bit cmp_en = 1'b0;

    always @(negedge CLK_FAST) begin
        if (cmp_en && RESET) begin
            check("cmd_valid", ifc.CMD_VALID, mq.size() != 0);
            check("level", ifc.LEVEL, mq.size());
            check("ovf", ifc.OVF, m_ovf);
            if (mq.size() != 0) begin
                check("cmd_reg", ifc.CMD_REG, mq[0][10:8]);
                check("cmd_data", ifc.CMD_DATA, mq[0][7:0]);
            end
        end
    end

    // Log of accepted commands, sampled just before each rising edge.
    logic [7:0] popped [$];

    always @(negedge CLK_FAST) begin
        #4;
        if (RESET && ifc.CMD_VALID && ifc.CMD_READY) popped.push_back(ifc.CMD_DATA);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // One PHI2 period: high for 'hi' samples, low for 'lo' negedges. The bus
    // is scrambled after the fall. With pulse_ready, CMD_READY is high for
    // exactly the edge on which this write reaches the FIFO.
    task automatic cpu_cycle(input bit en, input bit rw, input logic [2:0] r,
                             input logic [7:0] d, input int hi, input int lo,
                             input bit pulse_ready);
        @(negedge CLK_FAST);
        ifc.CLK_CPU = 1'b1;
        ifc.EN      = en;
        ifc.RW      = rw;
        ifc.REG     = r;
        ifc.DATA    = d;
        repeat (hi - 1) @(negedge CLK_FAST);
        @(negedge CLK_FAST);
        ifc.CLK_CPU = 1'b0;
        for (int j = 1; j <= lo; j++) begin
            @(negedge CLK_FAST);
            if (j == 1) begin
                ifc.EN   = 1'($urandom);
                ifc.RW   = 1'($urandom);
                ifc.REG  = 3'($urandom);
                ifc.DATA = 8'($urandom);
            end
            if (pulse_ready && j == 3) ifc.CMD_READY = 1'b1;
            if (pulse_ready && j == 4) ifc.CMD_READY = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge CLK_FAST);
        ifc.CMD_READY = 1'b1;
        while (ifc.LEVEL != 0 && k < 200) begin
            @(negedge CLK_FAST);
            k++;
        end
        check("drain_timeout", k < 200, 1'b1);
        ifc.CMD_READY = 1'b0;
    endtask

    bit         rand_done;
    logic [7:0] exp_q [$];
    logic [7:0] d;

    initial begin
        ifc.CLK_CPU   = 1'b0;
        ifc.EN        = 1'b1;
        ifc.RW        = 1'b1;
        ifc.REG       = '0;
        ifc.DATA      = '0;
        ifc.CMD_READY = 1'b0;
        ifc.CLR_OVF   = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK_FAST);
        #1;
        check("rst_level", ifc.LEVEL, 0);
        check("rst_valid", ifc.CMD_VALID, 0);
        check("rst_ovf", ifc.OVF, 0);
        @(negedge CLK_FAST);
        RESET  = 1'b1;
        cmp_en = 1'b1;

        // Single write: valid exactly three edges after the fall is sampled
        @(negedge CLK_FAST);
        ifc.CLK_CPU = 1'b1;
        ifc.EN = 1'b0; ifc.RW = 1'b0; ifc.REG = 3'd3; ifc.DATA = 8'h41;
        repeat (2) @(negedge CLK_FAST);
        ifc.CLK_CPU = 1'b0;
        @(posedge CLK_FAST);
        @(posedge CLK_FAST);
        @(posedge CLK_FAST);
        #1;
        check("single_early", ifc.CMD_VALID, 0);
        @(posedge CLK_FAST);
        #1;
        check("single_valid", ifc.CMD_VALID, 1);
        check("single_reg", ifc.CMD_REG, 3);
        check("single_data", ifc.CMD_DATA, 8'h41);
        check("single_level", ifc.LEVEL, 1);
        repeat (4) @(negedge CLK_FAST);
        check("single_once", ifc.LEVEL, 1);
        ifc.EN = 1'b1;
        drain();

        // Read cycles push nothing
        for (int i = 0; i < 10; i++) cpu_cycle(1'b0, 1'b1, 3'(i), 8'(i), 2, 2, 1'b0);
        repeat (4) @(negedge CLK_FAST);
        check("read_level", ifc.LEVEL, 0);
        check("read_valid", ifc.CMD_VALID, 0);

        // Fill past capacity: 17th write dropped, OVF set
        popped.delete();
        for (int i = 0; i < 17; i++) cpu_cycle(1'b0, 1'b0, 3'(i), 8'(8'h10 + i), 2, 2, 1'b0);
        repeat (4) @(negedge CLK_FAST);
        check("fill_level", ifc.LEVEL, 16);
        check("fill_ovf", ifc.OVF, 1);
        check("fill_head_data", ifc.CMD_DATA, 8'h10);
        check("fill_head_reg", ifc.CMD_REG, 0);

        ifc.CLR_OVF = 1'b1;
        @(negedge CLK_FAST);
        ifc.CLR_OVF = 1'b0;
        check("clr_ovf", ifc.OVF, 0);

        // Full FIFO with simultaneous pop: push accepted, level unchanged
        cpu_cycle(1'b0, 1'b0, 3'd7, 8'hAA, 2, 5, 1'b1);
        repeat (2) @(negedge CLK_FAST);
        check("fullpop_level", ifc.LEVEL, 16);
        check("fullpop_ovf", ifc.OVF, 0);
        drain();
        check("fill_pop_count", popped.size(), 17);
        if (popped.size() == 17) begin
            check("fill_first", popped[0], 8'h10);
            check("fill_16th", popped[15], 8'h1F);
            check("fullpop_last", popped[16], 8'hAA);
        end

        // Wrap: 40 writes with the consumer always ready
        popped.delete();
        exp_q.delete();
        @(negedge CLK_FAST);
        ifc.CMD_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            cpu_cycle(1'b0, 1'b0, 3'($urandom), d, 1 + int'($urandom % 2),
                      1 + int'($urandom % 2), 1'b0);
        end
        repeat (6) @(negedge CLK_FAST);
        ifc.CMD_READY = 1'b0;
        check("wrap_count", popped.size(), 40);
        check("wrap_level", ifc.LEVEL, 0);
        if (popped.size() == 40) begin
            for (int i = 0; i < 40; i++) check("wrap_order", popped[i], exp_q[i]);
        end

        // Random traffic: mixed reads/writes/deselects, bursty consumer
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++)
                    cpu_cycle(($urandom % 8) == 0, ($urandom % 8) == 0, 3'($urandom),
                              8'($urandom), 1 + int'($urandom % 3),
                              1 + int'($urandom % 3), 1'b0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge CLK_FAST);
                    ifc.CMD_READY = ($urandom % 8) == 0;
                    ifc.CLR_OVF   = ($urandom % 16) == 0;
                end
                ifc.CMD_READY = 1'b0;
                ifc.CLR_OVF   = 1'b0;
            end
        join
        repeat (4) @(negedge CLK_FAST);
        drain();

        // Reset mid-burst: stored and in-flight commands discarded
        for (int i = 0; i < 5; i++) cpu_cycle(1'b0, 1'b0, 3'(i), 8'(8'h50 + i), 2, 2, 1'b0);
        repeat (4) @(negedge CLK_FAST);
        check("burst_level", ifc.LEVEL, 5);
        cpu_cycle(1'b0, 1'b0, 3'd1, 8'h99, 2, 1, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_rst_level", ifc.LEVEL, 0);
        check("mid_rst_valid", ifc.CMD_VALID, 0);
        check("mid_rst_ovf", ifc.OVF, 0);
        @(negedge CLK_FAST);
        RESET = 1'b1;
        repeat (6) @(negedge CLK_FAST);
        check("inflight_dropped", ifc.LEVEL, 0);
        cpu_cycle(1'b0, 1'b0, 3'd5, 8'h77, 2, 2, 1'b0);
        repeat (4) @(negedge CLK_FAST);
        check("post_rst_level", ifc.LEVEL, 1);
        check("post_rst_data", ifc.CMD_DATA, 8'h77);
        check("post_rst_reg", ifc.CMD_REG, 5);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks",
                 n_err, n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/vga_bus_capture.md
VGA_BUS_CAPTURE -- requirements
Module: vga_bus_capture

Interface
REQ-001 Parameter: DEPTH, 16, command FIFO entries; power of two, 4..64.
REQ-002 Port: CLK_FAST  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: RESET  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-004 Port: CLK_CPU  input  1  6502 PHI2, asynchronous to CLK_FAST.
REQ-005 Port: EN  input  1  chip enable, active-low, asynchronous.
REQ-006 Port: RW  input  1  CPU read/write; 0 = write; asynchronous.
REQ-007 Port: REG  input  3  register select, asynchronous.
REQ-008 Port: DATA  input  8  CPU write data, asynchronous.
REQ-009 Port: CMD_VALID  output  1  FIFO head holds a command.
REQ-010 Port: CMD_REG  output  3  head register index, bits [10:8] of entry.
REQ-011 Port: CMD_DATA  output  8  head data byte, bits [7:0] of entry.
REQ-012 Port: CMD_READY  input  1  consumer accepts head this cycle.
REQ-013 Port: LEVEL  output  log2(DEPTH)+1  entries currently stored.
REQ-014 Port: OVF  output  1  sticky overflow flag.
REQ-015 Port: CLR_OVF  input  1  synchronous clear of OVF.

Function
REQ-016 CLK_CPU SHALL pass through three flops (c1,c2,c3); {EN,RW,REG,DATA} SHALL pass through three parallel flops (b1,b2,b3) in lockstep.
REQ-017 Write strobe SHALL be c3=1 & c2=0 (PHI2 fall) with b3.EN=0 & b3.RW=0; b3 is the last bus sample taken while PHI2 was high.
REQ-018 On strobe the entry {b3.REG, b3.DATA} SHALL be pushed; exactly one push per PHI2 fall, regardless of how long PHI2 stays low.
REQ-019 Strobe with b3.RW=1 or b3.EN=1 SHALL push nothing (reads ignored by this block).
REQ-020 Latency: PHI2 fall at CLK_FAST edge n (first sampled 0 into c1) -> push at edge n+2 -> CMD_VALID=1 after edge n+3 when FIFO was empty.
REQ-021 FIFO SHALL be first-word-fall-through: CMD_VALID = (LEVEL!=0); CMD_REG/CMD_DATA show head combinationally from storage, stable while CMD_VALID & !CMD_READY.
REQ-022 Pop SHALL occur on CMD_VALID & CMD_READY; CMD_READY while empty SHALL have no effect.
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; LEVEL SHALL track pushes minus pops exactly.
REQ-024 Push and pop in the same cycle: both SHALL take effect, LEVEL unchanged; when full this push SHALL be accepted (pop frees the slot).
REQ-025 Push when LEVEL=DEPTH and no pop: entry SHALL be dropped, FIFO unchanged, OVF set to 1 next edge.
REQ-026 Push when empty with CMD_READY=1: entry SHALL be stored, not bypassed; pop possible from next cycle.
REQ-027 OVF SHALL remain 1 until CLR_OVF=1 sampled; overflow and CLR_OVF in same cycle SHALL leave OVF=1.
REQ-028 Command order SHALL equal CPU write order; no entry duplicated or reordered.

Reset
REQ-029 RESET=0 SHALL asynchronously clear c1..c3, b1..b3, pointers, LEVEL, OVF; CMD_VALID=0, LEVEL=0, OVF=0 while asserted.
REQ-030 Sync flops reset to 0 so no PHI2 fall is detected until PHI2 has been sampled high after release.
REQ-031 Reset asserted mid-burst SHALL discard all stored and in-flight commands; FIFO storage contents need not be cleared.
REQ-032 Reset release SHALL be synchronous to CLK_FAST externally; block operates from first edge after release.

Verification
REQ-033 Single write: REG=3, DATA=0x41, EN=0, RW=0, PHI2 fall -> CMD_VALID=1 with CMD_REG=3, CMD_DATA=0x41, LEVEL=1, 3 edges after fall sampled.
REQ-034 Read cycle: EN=0, RW=1, PHI2 toggled 10 times -> LEVEL stays 0, CMD_VALID=0.
REQ-035 Fill: 17 writes, CMD_READY=0, DEPTH=16 -> LEVEL=16, OVF=1, head = first write, 17th absent after drain.
REQ-036 Full with simultaneous pop: LEVEL=16, CMD_READY=1 during push -> LEVEL=16, OVF=0, new entry appears last.
REQ-037 Wrap: 40 writes with CMD_READY=1 -> 40 commands popped in order, values match, LEVEL returns 0.
REQ-038 Reset mid-burst: 5 queued, RESET=0 one cycle -> LEVEL=0, CMD_VALID=0, OVF=0 immediately; next write appears as sole entry.
